debouncer_multi: RTL and testbench
==================================

Name: debouncer_multi

Overview:
Parametrised N-channel successor to the single-switch debouncer, for button/switch banks on the test boards.
- Per channel: 2-flop input synchronisation, shared sample-tick prescaler, per-channel stability counter.
- Per channel outputs: debounced level, one-cycle rise/fall pulses, optional long-press pulse.
- Sits between board pins and the test-harness control logic; replaces per-pin debouncer instances.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
TICK_DIV, 1, clocks per sample tick (>=1); 1 = sample every clock
STABLE_TICKS, 4, consecutive differing ticks before debounced state flips (>=1)
LONG_TICKS, 0, ticks o_Switch must stay 1 before o_Long pulses; 0 disables long-press logic
RESET_VAL, 0, NUM_CH-bit reset value of synchronisers and debounced state

Ports:
i_Clk  input  1  clock
i_Rst_n  input  1  asynchronous active-low reset; asynchronous assert, synchronous-to-i_Clk deassert handled upstream
i_Switch  input  NUM_CH  raw asynchronous switch inputs
o_Switch  output  NUM_CH  debounced levels
o_Rise  output  NUM_CH  one-cycle pulse when o_Switch bit goes 0->1
o_Fall  output  NUM_CH  one-cycle pulse when o_Switch bit goes 1->0
o_Long  output  NUM_CH  one-cycle pulse on long press; constant 0 if LONG_TICKS==0
o_Any_Event  output  1  OR of all o_Rise/o_Fall/o_Long bits, same cycle

Behaviour:
- Reset (i_Rst_n=0, async): sync flops and o_Switch = RESET_VAL; all counters = 0; o_Rise/o_Fall/o_Long/o_Any_Event = 0; prescaler = 0.
- No pulses on reset release, even if i_Switch differs from RESET_VAL. The difference is debounced normally and produces a normal pulse.
- Synchroniser: 2 flops per bit. s = second flop.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick = (count == TICK_DIV-1), then count wraps to 0.
  - TICK_DIV==1: tick is constant 1, no counter.
  - Prescaler is shared by all channels.
- Per channel, each clock, in priority order:
  1. s == o_Switch: cnt <= 0 immediately, without waiting for a tick.
  2. s != o_Switch, tick, cnt == STABLE_TICKS-1: o_Switch <= s; cnt <= 0; o_Rise or o_Fall <= 1 for exactly this cycle's update (registered, coincident with the o_Switch change).
  3. s != o_Switch, tick: cnt <= cnt+1.
  4. Otherwise: hold.
- Counter width: $clog2(STABLE_TICKS+1). cnt never exceeds STABLE_TICKS-1.
- Latency (TICK_DIV=1): i_Switch change set up before edge E0 makes o_Switch change at edge E0+1+STABLE_TICKS, i.e. STABLE_TICKS+2 edges counting E0. Pulse coincides with that edge.
- Glitch rejection: any return of s to o_Switch before the count completes resets cnt. No output change, no pulse.
- Long press (LONG_TICKS>0):
  - hcnt counts ticks while o_Switch==1; width $clog2(LONG_TICKS+1).
  - When hcnt reaches LONG_TICKS on a tick: o_Long pulses once and hcnt saturates. No repeat pulse until release.
  - o_Switch==0 clears hcnt and re-arms the pulse.
  - o_Fall and o_Long are never asserted in the same cycle for one channel: fall has priority, and the long pulse is suppressed.
- Channels are fully independent. Any combination of per-channel pulses may assert in one cycle.
- o_Any_Event is a registered OR matching the pulse registers, so it coincides with the pulses, not one cycle later.
- Reset mid-count: all progress discarded and outputs return to RESET_VAL asynchronously.

Decomposition:
- Shared package debouncer_pkg:
  - Default constants DEB_TICK_DIV_DEFAULT, DEB_STABLE_DEFAULT, DEB_LONG_DEFAULT.
  - Width helper: clog2 of (n+1).
- Sub-module debouncer_ch: one channel (synchroniser, stability counter, long counter, pulse regs). Takes tick as input and is instantiated NUM_CH times in a generate loop.
- Top holds the prescaler and the o_Any_Event OR.

Test Plan:
1. Reset/clean step: RESET_VAL=0, TICK_DIV=1, STABLE_TICKS=4. Raise i_Switch[0] before E0 -> o_Switch[0]=1 and o_Rise[0]=1 at E5 only. o_Any_Event high that cycle. Other channels stay 0.
2. Glitch: i_Switch[1] high for 3 clocks then low -> o_Switch[1] stays 0, no pulses. High for 5 clocks -> rises. Returning low for >=6 clocks -> single o_Fall[1] pulse.
3. Prescaler: TICK_DIV=3, STABLE_TICKS=2. Step input -> o_Switch changes after 2 ticks (6 clocks ±2 for tick phase, plus 2 sync clocks). Chatter toggling every 2 clocks never flips output.
4. Long press: LONG_TICKS=10, TICK_DIV=1. Hold channel 2 high 30 clocks -> o_Rise[2] once, o_Long[2] exactly once, 10 clocks after the rise. Release -> o_Fall[2]. Re-press re-arms the long pulse.
5. Simultaneous: toggle all 4 channels in the same cycle -> o_Rise=4'b1111 for one cycle, o_Any_Event=1 for one cycle.
6. Reset mid-operation: assert i_Rst_n=0 while channel 3 is 2 counts into debounce and o_Switch=4'b0001. Outputs go to 0 asynchronously. After release with inputs high -> normal debounce and one o_Rise per high channel, none at the release edge.

Source files
------------

// File: rtl/debouncer_pkg.sv
// Shared constants and helpers for the multi-channel switch debouncer.
package debouncer_pkg;
  localparam int DEB_TICK_DIV_DEFAULT = 1;
  localparam int DEB_STABLE_DEFAULT   = 4;
  localparam int DEB_LONG_DEFAULT     = 0;

  typedef struct packed {
    logic rise;
    logic fall;
    logic lng;
  } deb_evt_t;

  // Width that can hold 0..n; never below 1 so disabled counters still declare cleanly.
  function automatic int deb_cw(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/debouncer_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, long-press counter, pulse regs.
module debouncer_ch
  import debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = DEB_STABLE_DEFAULT,
  parameter int   LONG_TICKS   = DEB_LONG_DEFAULT,
  parameter logic RST_BIT      = 1'b0
) (
  input  logic     i_Clk,
  input  logic     i_Rst_n,
  input  logic     i_Tick,
  input  logic     i_Raw,
  output logic     o_Level,
  output deb_evt_t o_Evt,
  output logic     o_Evt_Nxt
);
  localparam int CW = deb_cw(STABLE_TICKS);

  logic          meta, s;
  logic [CW-1:0] cnt, cnt_d;
  logic          lvl_d, rise_d, fall_d, long_d;

  always_comb begin
    cnt_d  = cnt;
    lvl_d  = o_Level;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s == o_Level) begin
      cnt_d = '0;
    end else if (i_Tick) begin
      if (cnt == CW'(STABLE_TICKS - 1)) begin
        lvl_d  = s;
        cnt_d  = '0;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt + CW'(1);
      end
    end
  end

  generate
    if (LONG_TICKS > 0) begin : g_long
      localparam int HW = deb_cw(LONG_TICKS);
      logic [HW-1:0] hcnt, hcnt_d;

      // hcnt saturates at LONG_TICKS so the pulse fires once per press.
      always_comb begin
        hcnt_d = hcnt;
        long_d = 1'b0;
        if (!o_Level) begin
          hcnt_d = '0;
        end else if (i_Tick && hcnt != HW'(LONG_TICKS)) begin
          hcnt_d = hcnt + HW'(1);
          long_d = (hcnt == HW'(LONG_TICKS - 1)) && !fall_d;
        end
      end

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) hcnt <= '0;
        else          hcnt <= hcnt_d;
      end
    end else begin : g_nolong
      assign long_d = 1'b0;
    end
  endgenerate

  assign o_Evt_Nxt = rise_d | fall_d | long_d;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta    <= RST_BIT;
      s       <= RST_BIT;
      o_Level <= RST_BIT;
      cnt     <= '0;
      o_Evt   <= '0;
    end else begin
      meta    <= i_Raw;
      s       <= meta;
      o_Level <= lvl_d;
      cnt     <= cnt_d;
      o_Evt   <= '{rise: rise_d, fall: fall_d, lng: long_d};
    end
  end
endmodule

// File: rtl/debouncer_multi.sv
// N-channel switch debouncer: shared sample-tick prescaler, per-channel debounce, event OR.
module debouncer_multi
  import debouncer_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                TICK_DIV     = DEB_TICK_DIV_DEFAULT,
  parameter int                STABLE_TICKS = DEB_STABLE_DEFAULT,
  parameter int                LONG_TICKS   = DEB_LONG_DEFAULT,
  parameter logic [NUM_CH-1:0] RESET_VAL    = '0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic [NUM_CH-1:0] o_Long,
  output logic              o_Any_Event
);
  logic              tick;
  logic [NUM_CH-1:0] evt_nxt;
  deb_evt_t          evt [NUM_CH];

  generate
    if (TICK_DIV > 1) begin : g_presc
      localparam int PW = $clog2(TICK_DIV);
      logic [PW-1:0] pcnt;

      assign tick = (pcnt == PW'(TICK_DIV - 1));

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)  pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
      end
    end else begin : g_nopresc
      assign tick = 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debouncer_ch #(
        .STABLE_TICKS (STABLE_TICKS),
        .LONG_TICKS   (LONG_TICKS),
        .RST_BIT      (RESET_VAL[i])
      ) u_ch (
        .i_Clk     (i_Clk),
        .i_Rst_n   (i_Rst_n),
        .i_Tick    (tick),
        .i_Raw     (i_Switch[i]),
        .o_Level   (o_Switch[i]),
        .o_Evt     (evt[i]),
        .o_Evt_Nxt (evt_nxt[i])
      );
      assign o_Rise[i] = evt[i].rise;
      assign o_Fall[i] = evt[i].fall;
      assign o_Long[i] = evt[i].lng;
    end
  endgenerate

  // Registered from the channels' next-pulse terms so it lines up with the pulses.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) o_Any_Event <= 1'b0;
    else          o_Any_Event <= |evt_nxt;
  end
endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: two configurations checked every cycle against a behavioural model.
module tb_debouncer_multi;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_a  = 4'b0000;
  logic [3:0] sw_b  = 4'b0101;
  logic [3:0] so_a, ri_a, fa_a, lo_a, so_b, ri_b, fa_b, lo_b;
  logic       any_a, any_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debouncer_multi #(.NUM_CH(4), .TICK_DIV(1), .STABLE_TICKS(4), .LONG_TICKS(10),
                    .RESET_VAL(4'b0000)) u_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw_a), .o_Switch(so_a), .o_Rise(ri_a),
    .o_Fall(fa_a), .o_Long(lo_a), .o_Any_Event(any_a));

  debouncer_multi #(.NUM_CH(4), .TICK_DIV(3), .STABLE_TICKS(2), .LONG_TICKS(0),
                    .RESET_VAL(4'b0101)) u_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Switch(sw_b), .o_Switch(so_b), .o_Rise(ri_b),
    .o_Fall(fa_b), .o_Long(lo_b), .o_Any_Event(any_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: unbounded run/hold counters, tick derived from edge index.
  int         P_DIV  [2] = '{1, 3};
  int         P_STAB [2] = '{4, 2};
  int         P_LONG [2] = '{10, 0};
  logic [3:0] P_RV   [2] = '{4'b0000, 4'b0101};
  int h1 [2][4], h2 [2][4], outm [2][4], run [2][4], held [2][4];
  bit rm [2][4], fm [2][4], lm [2][4];
  int ecnt [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = 0;
      for (int c = 0; c < 4; c++) begin
        h1[d][c] = int'(P_RV[d][c]); h2[d][c] = int'(P_RV[d][c]);
        outm[d][c] = int'(P_RV[d][c]);
        run[d][c] = 0; held[d][c] = 0;
        rm[d][c] = 0; fm[d][c] = 0; lm[d][c] = 0;
      end
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] in);
    bit tk;
    int s, prev;
    tk = (ecnt[d] % P_DIV[d]) == P_DIV[d] - 1;
    ecnt[d]++;
    for (int c = 0; c < 4; c++) begin
      s = h2[d][c];
      prev = outm[d][c];
      rm[d][c] = 0; fm[d][c] = 0; lm[d][c] = 0;
      if (s == prev) run[d][c] = 0;
      else if (tk) begin
        run[d][c]++;
        if (run[d][c] == P_STAB[d]) begin
          outm[d][c] = s; run[d][c] = 0;
          rm[d][c] = (s == 1); fm[d][c] = (s == 0);
        end
      end
      if (P_LONG[d] > 0) begin
        if (prev == 1) begin
          if (tk) begin
            held[d][c]++;
            if (held[d][c] == P_LONG[d] && !fm[d][c]) lm[d][c] = 1;
          end
        end else held[d][c] = 0;
      end
      h2[d][c] = h1[d][c];
      h1[d][c] = int'(in[c]);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_step(0, sw_a);
        model_step(1, sw_b);
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [3:0] es, er, ef, el;
        string      p;
        for (int c = 0; c < 4; c++) begin
          es[c] = (outm[d][c] != 0); er[c] = rm[d][c]; ef[c] = fm[d][c]; el[c] = lm[d][c];
        end
        p = (d == 0) ? "a" : "b";
        chk({p, "_switch"}, (d == 0) ? so_a : so_b, es);
        chk({p, "_rise"},   (d == 0) ? ri_a : ri_b, er);
        chk({p, "_fall"},   (d == 0) ? fa_a : fa_b, ef);
        chk({p, "_long"},   (d == 0) ? lo_a : lo_b, el);
        chk({p, "_any"},    (d == 0) ? any_a : any_b, |(er | ef | el));
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_sw_a", so_a, 4'b0000);
    chk("rst_sw_b", so_b, 4'b0101);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean step on ch0: flip exactly at E5
    sw_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t1_e4_sw", so_a[0], 1'b0);
    @(negedge clk);
    chk("t1_e5_sw", so_a, 4'b0001);
    chk("t1_e5_rise", ri_a, 4'b0001);
    chk("t1_e5_any", any_a, 1'b1);
    @(negedge clk);
    chk("t1_e6_rise", ri_a, 4'b0000);

    // Glitch rejection, then a real press and release on ch1
    sw_a[1] = 1'b1;
    repeat (3) @(negedge clk);
    sw_a[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk("t2_glitch_sw", so_a[1], 1'b0);
    sw_a[1] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t2_e4_sw", so_a[1], 1'b0);
    sw_a[1] = 1'b0;
    @(negedge clk);
    chk("t2_e5_sw", so_a[1], 1'b1);
    chk("t2_e5_rise", ri_a, 4'b0010);
    repeat (4) @(negedge clk);
    chk("t2_e9_sw", so_a[1], 1'b1);
    @(negedge clk);
    chk("t2_e10_fall", fa_a, 4'b0010);
    chk("t2_e10_sw", so_a[1], 1'b0);

    // Long press on ch2: rise E5, long E15 once, fall, re-arm
    sw_a[2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_rise", ri_a[2], 1'b1);
    repeat (9) @(negedge clk);
    chk("t4_e14_long", lo_a[2], 1'b0);
    @(negedge clk);
    chk("t4_e15_long", lo_a[2], 1'b1);
    @(negedge clk);
    chk("t4_e16_long", lo_a[2], 1'b0);
    repeat (14) @(negedge clk);
    sw_a[2] = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_fall", fa_a[2], 1'b1);
    sw_a[2] = 1'b1;
    repeat (16) @(negedge clk);
    chk("t4_rearm_long", lo_a[2], 1'b1);

    // Fall and long due on the same edge on ch3: fall wins
    sw_a[3] = 1'b1;
    repeat (10) @(negedge clk);
    sw_a[3] = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_prio_fall", fa_a[3], 1'b1);
    chk("t4_prio_long", lo_a[3], 1'b0);

    // All channels rise together
    sw_a = 4'b0000;
    repeat (12) @(negedge clk);
    sw_a = 4'b1111;
    repeat (5) @(negedge clk);
    chk("t5_e4_rise", ri_a, 4'b0000);
    @(negedge clk);
    chk("t5_e5_rise", ri_a, 4'b1111);
    chk("t5_e5_any", any_a, 1'b1);
    @(negedge clk);
    chk("t5_e6_rise", ri_a, 4'b0000);
    chk("t5_e6_any", any_a, 1'b0);

    // Reset with ch3 two counts into debounce
    sw_a = 4'b0001;
    repeat (12) @(negedge clk);
    chk("t6_pre_sw", so_a, 4'b0001);
    sw_a[3] = 1'b1;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_sw", so_a, 4'b0000);
    chk("t6_async_evt", {ri_a, fa_a, lo_a, 3'b000, any_a}, 16'h0000);
    sw_a = 4'b1011;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rel_rise", ri_a, 4'b0000);
    chk("t6_rel_any", any_a, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_e4_sw", so_a, 4'b0000);
    @(negedge clk);
    chk("t6_e5_rise", ri_a, 4'b1011);
    chk("t6_e5_sw", so_a, 4'b1011);

    // Prescaled config: step latency window and chatter rejection
    sw_b[1] = 1'b1;
    k = 0;
    while (so_b[1] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t3_latency_window", (k >= 6 && k <= 8), 1'b1);
    for (int i = 0; i < 10; i++) begin
      sw_b[3] = ~sw_b[3];
      repeat (2) @(negedge clk);
    end
    sw_b[3] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_chatter_sw", so_b[3], 1'b0);
    chk("t3_other_sw", so_b, 4'b0111);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
